// File: rtl/keypad_emulator.sv
// keypad_emulator: drives a 4x3 keypad's column lines as a bouncing contact for one latched key.
// Ports: clock/reset (async active-high), key_code+press_req start a press,
// row is the scanner's live row drive, col the emulated columns, busy/done/err report status.
module keypad_emulator #(
  parameter int BOUNCE_PERIOD  = 8,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int HOLD_CYCLES    = 20000,
  parameter int GAP_CYCLES     = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       press_req,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_BIN = 3'd1, S_HOLD = 3'd2, S_BOUT = 3'd3, S_GAP = 3'd4;
  localparam logic [15:0] L_PER    = 16'(BOUNCE_PERIOD);
  localparam logic [15:0] L_BOUNCE = 16'(BOUNCE_TOGGLES * BOUNCE_PERIOD - 1);
  localparam logic [15:0] L_HOLD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] L_GAP    = 16'(GAP_CYCLES - 1);
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_key;
  logic        r_contact, r_done, r_err;
  logic        w_tick, w_last;
  logic [1:0]  w_row_sel;
  logic [2:0]  w_col_oh;
  // the counter runs across a whole bounce phase; a toggle falls on the last cycle of each period
  assign w_tick = (r_cnt % L_PER) == (L_PER - 16'd1);
  assign w_last = (r_state == S_HOLD) ? (r_cnt == L_HOLD) :
                  (r_state == S_GAP)  ? (r_cnt == L_GAP)  : (r_cnt == L_BOUNCE);
  always_comb begin
    w_row_sel = 2'd3;
    w_col_oh  = 3'b000;
    case (r_key)
      4'd1:  begin w_row_sel = 2'd0; w_col_oh = 3'b001; end
      4'd2:  begin w_row_sel = 2'd0; w_col_oh = 3'b010; end
      4'd3:  begin w_row_sel = 2'd0; w_col_oh = 3'b100; end
      4'd4:  begin w_row_sel = 2'd1; w_col_oh = 3'b001; end
      4'd5:  begin w_row_sel = 2'd1; w_col_oh = 3'b010; end
      4'd6:  begin w_row_sel = 2'd1; w_col_oh = 3'b100; end
      4'd7:  begin w_row_sel = 2'd2; w_col_oh = 3'b001; end
      4'd8:  begin w_row_sel = 2'd2; w_col_oh = 3'b010; end
      4'd9:  begin w_row_sel = 2'd2; w_col_oh = 3'b100; end
      4'd10: begin w_row_sel = 2'd3; w_col_oh = 3'b001; end
      4'd0:  begin w_row_sel = 2'd3; w_col_oh = 3'b010; end
      4'd11: begin w_row_sel = 2'd3; w_col_oh = 3'b100; end
      default: begin w_row_sel = 2'd3; w_col_oh = 3'b000; end
    endcase
  end
  assign col  = (r_contact && row[w_row_sel]) ? w_col_oh : 3'b000;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign err  = r_err;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_key     <= '0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (press_req) begin
          if (key_code <= 4'd11) begin
            r_key     <= key_code;
            r_contact <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_BIN;
          end else r_err <= 1'b1;
        end
        S_BIN, S_BOUT: begin
          if (w_tick) r_contact <= ~r_contact;
          r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
          if (w_last) r_state <= (r_state == S_BIN) ? S_HOLD : S_GAP;
        end
        S_HOLD: begin
          r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
          if (w_last) begin
            r_contact <= 1'b0;
            r_state   <= S_BOUT;
          end
        end
        S_GAP: begin
          r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed scoreboard bench for keypad_emulator with short timing parameters.
module tb_keypad_emulator;
  localparam int P = 2, T = 2, H = 10, G = 4;
  localparam int BUSY = 2 * T * P + H + G;
  logic       clock = 1'b0, reset = 1'b1, press_req = 1'b0;
  logic [3:0] key_code = 4'd0, row = 4'b1111;
  logic [2:0] col;
  logic       busy, done, err;
  int tests = 0, fails = 0;
  logic [5:0] q[$];
  keypad_emulator #(.BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(T), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .key_code(key_code), .press_req(press_req),
    .row(row), .col(col), .busy(busy), .done(done), .err(err));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed {col,busy,done,err}=%b expected %b", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] row_of(input int mode, input int i);
    case (mode)
      0: return 4'b0010;
      1: return 4'b0001;
      2: return 4'(1 << (i % 4));
      default: return 4'b1000;
    endcase
  endfunction
  function automatic logic closed_at(input int i);
    if (i < T * P) return ((i / P) % 2) == 0;
    if (i < T * P + H) return 1'b1;
    if (i < 2 * T * P + H) return (((i - T * P - H) / P) % 2) == 1;
    return 1'b0;
  endfunction
  // press starts with press_req driven in the current cycle; stop<0 runs through the done cycle
  task automatic press(input int k, input int mode, input int poke, input int stop, input string tag);
    int kr, kc;
    logic [3:0] r;
    kr = (k >= 1 && k <= 9) ? (k - 1) / 3 : 3;
    kc = (k >= 1 && k <= 9) ? (k - 1) % 3 : (k == 10) ? 0 : (k == 0) ? 1 : 2;
    for (int i = 0; i <= BUSY; i++) begin
      r = row_of(mode, i);
      q.push_back({(closed_at(i) && r[kr]) ? 3'(1 << kc) : 3'b000, i < BUSY, i == BUSY, 1'b0});
    end
    key_code = 4'(k);
    press_req = 1'b1;
    @(posedge clock); #1;
    press_req = 1'b0;
    for (int i = 0; i <= BUSY; i++) begin
      row = row_of(mode, i);
      #1;
      check($sformatf("%s cyc%0d", tag, i), {col, busy, done, err}, q.pop_front());
      if (i == stop) begin q.delete(); return; end
      if (i == BUSY) return;
      if (i == poke) begin key_code = 4'd3; press_req = 1'b1; end
      @(posedge clock); #1;
      press_req = 1'b0;
    end
  endtask
  initial begin
    #2;
    check("reset_async", {col, busy, done, err}, 6'b000000);
    @(posedge clock); #1;
    check("reset_held", {col, busy, done, err}, 6'b000000);
    reset = 1'b0;
    @(posedge clock); #1;
    press(5, 0, -1, -1, "key5_row2");
    @(posedge clock); #1;
    check("after_done", {col, busy, done, err}, 6'b000000);
    press(5, 1, -1, -1, "key5_row1");
    @(posedge clock); #1;
    press(11, 2, -1, -1, "hash_scan");
    @(posedge clock); #1;
    key_code = 4'd13; press_req = 1'b1; row = 4'b1111;
    @(posedge clock); #1;
    press_req = 1'b0;
    check("invalid_err", {col, busy, done, err}, 6'b000001);
    @(posedge clock); #1;
    check("invalid_after", {col, busy, done, err}, 6'b000000);
    press(7, 2, 2 * P + 3, -1, "key7_poke");
    press(9, 2, -1, -1, "key9_back2back");
    @(posedge clock); #1;
    press(0, 3, -1, 2 * P + 4, "key0_abort");
    reset = 1'b1;
    #1;
    check("abort_reset", {col, busy, done, err}, 6'b000000);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < BUSY + 2; i++) begin
      @(posedge clock); #1;
      check($sformatf("abort_quiet%0d", i), {col, busy, done, err}, 6'b000000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
